// File: rtl/vend_pkg.sv
// vend_pkg: shared slot/coin types and dispense state encoding for the vend actuator slice
package vend_pkg;
    localparam int NUM_ITEMS = 4;
    localparam int SLOT_W = 2;
    typedef logic [SLOT_W-1:0] slot_t;
    typedef logic [2:0] coin_t;
    typedef enum logic [1:0] {ST_IDLE, ST_MOTOR, ST_PAY_HI, ST_PAY_LO} vend_state_e;
endpackage

// File: rtl/vend_dispense_ctrl_if.sv
// vend_dispense_ctrl_if: vending machine results, sensors, refill and actuator outputs
interface vend_dispense_ctrl_if import vend_pkg::*; #(parameter int STOCK_W = 4);
    logic pdt;
    slot_t sel;
    coin_t cng;
    coin_t rtn;
    logic drop_sense;
    logic refill;
    slot_t refill_sel;
    logic [STOCK_W-1:0] refill_qty;
    logic fault_clr;
    logic [NUM_ITEMS-1:0] motor;
    logic coin_pulse;
    logic busy;
    logic fault;
    logic [NUM_ITEMS-1:0] item_available;
    logic [STOCK_W-1:0] stock_level;
    modport master (
        output pdt, sel, cng, rtn, drop_sense, refill, refill_sel, refill_qty, fault_clr,
        input motor, coin_pulse, busy, fault, item_available, stock_level
    );
    modport slave (
        input pdt, sel, cng, rtn, drop_sense, refill, refill_sel, refill_qty, fault_clr,
        output motor, coin_pulse, busy, fault, item_available, stock_level
    );
endinterface

// File: rtl/vend_coin_pulser.sv
// vend_coin_pulser: emits count hopper pulses of PULSE_HI high / PULSE_LO low cycles
module vend_coin_pulser import vend_pkg::*; #(
    parameter int PULSE_HI = 2,
    parameter int PULSE_LO = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  coin_t count,
    output logic  coin_pulse,
    output logic  done
);
    localparam int TW = $clog2((PULSE_HI > PULSE_LO ? PULSE_HI : PULSE_LO) + 1);
    localparam logic [1:0] P_IDLE = ST_IDLE;
    localparam logic [1:0] P_HI = ST_PAY_HI;
    localparam logic [1:0] P_LO = ST_PAY_LO;
    logic [1:0] phase;
    logic [TW-1:0] tmr;
    coin_t cnt;
    logic last_hi, last_lo;
    assign last_hi = tmr == TW'(PULSE_HI - 1);
    assign last_lo = tmr == TW'(PULSE_LO - 1);
    assign coin_pulse = phase == P_HI;
    assign done = phase == P_LO && last_lo && cnt == '0;
    // high/low phase timer; the coin count drops as each low gap begins
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase <= P_IDLE;
            tmr <= '0;
            cnt <= '0;
        end else if (start) begin
            phase <= count != '0 ? P_HI : P_IDLE;
            tmr <= '0;
            cnt <= count;
        end else if (phase == P_HI) begin
            tmr <= last_hi ? '0 : tmr + 1'b1;
            if (last_hi) begin
                phase <= P_LO;
                cnt <= cnt - 1'b1;
            end
        end else if (phase == P_LO) begin
            tmr <= last_lo ? '0 : tmr + 1'b1;
            if (last_lo) phase <= cnt != '0 ? P_HI : P_IDLE;
        end
    end
endmodule

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: sequences item motors and the coin hopper, tracks per-slot stock
module vend_dispense_ctrl import vend_pkg::*; #(
    parameter int STOCK_W = 4,
    parameter int STOCK_INIT = 4,
    parameter int MOTOR_TIMEOUT = 16,
    parameter int PULSE_HI = 2,
    parameter int PULSE_LO = 2
) (
    input logic clk,
    input logic rst,
    vend_dispense_ctrl_if.slave bus
);
    localparam int TW = $clog2(MOTOR_TIMEOUT + 1);
    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] MOTOR = ST_MOTOR;
    localparam logic [1:0] PAY = ST_PAY_HI;
    logic [1:0] state;
    slot_t sel_q;
    coin_t pay_cnt, count;
    logic [TW-1:0] tmr;
    logic pdt_prev, rtn_nz_prev, fault_q;
    logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock, stock_nx;
    logic [STOCK_W:0] sum [NUM_ITEMS];
    logic [NUM_ITEMS-1:0] dec, add, avail;
    logic idle, vend_ev, ref_ev, have, dec_ok, motor_exit, start, done, fault_set;
    assign idle = state == IDLE;
    assign vend_ev = bus.pdt & ~pdt_prev;
    assign ref_ev = (bus.rtn != '0) & ~rtn_nz_prev;
    assign have = stock[bus.sel] != '0;
    assign dec_ok = idle & vend_ev & have;
    assign motor_exit = state == MOTOR && (bus.drop_sense || tmr == TW'(MOTOR_TIMEOUT - 1));
    assign start = idle ? (vend_ev ? !have && bus.cng != '0 : ref_ev) : motor_exit && pay_cnt != '0;
    assign count = idle ? (vend_ev ? bus.cng : bus.rtn) : pay_cnt;
    assign fault_set = (idle & vend_ev & ~have) | (motor_exit & ~bus.drop_sense);
    assign bus.motor = state == MOTOR ? NUM_ITEMS'(1) << sel_q : '0;
    assign bus.busy = !idle;
    assign bus.fault = fault_q;
    assign bus.item_available = avail;
    assign bus.stock_level = stock[bus.refill_sel];
    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_slot
        assign dec[i] = dec_ok && bus.sel == SLOT_W'(i);
        assign add[i] = bus.refill && bus.refill_sel == SLOT_W'(i);
        assign sum[i] = {1'b0, stock[i]} - (STOCK_W + 1)'(dec[i]) + (add[i] ? {1'b0, bus.refill_qty} : '0);
        assign stock_nx[i] = sum[i][STOCK_W] ? '1 : sum[i][STOCK_W-1:0];
        assign avail[i] = stock[i] != '0;
    end
    vend_coin_pulser #(.PULSE_HI(PULSE_HI), .PULSE_LO(PULSE_LO)) u_pulser (
        .clk(clk),
        .rst(rst),
        .start(start),
        .count(count),
        .coin_pulse(bus.coin_pulse),
        .done(done)
    );
    // dispense sequencing, edge capture, motor timer and sticky fault
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            sel_q <= '0;
            pay_cnt <= '0;
            tmr <= '0;
            pdt_prev <= 1'b0;
            rtn_nz_prev <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pdt_prev <= bus.pdt;
            rtn_nz_prev <= bus.rtn != '0;
            tmr <= state == MOTOR ? tmr + 1'b1 : '0;
            fault_q <= fault_set | (fault_q & ~bus.fault_clr);
            if (dec_ok) begin
                state <= MOTOR;
                sel_q <= bus.sel;
                pay_cnt <= bus.cng;
            end else if (start) begin
                state <= PAY;
            end else if (motor_exit || (state == PAY && done)) begin
                state <= IDLE;
            end
        end
    end
    // stock counters: vend decrement and saturating refill merge in one update
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= !rst ? STOCK_W'(STOCK_INIT) : stock_nx[i];
    end
endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
Actuator sequencer that sits downstream of vending_machine.
- Turns the machine's pdt/cng/rtn results into timed commands for the item motors and the coin hopper.
- Keeps per-slot stock counters and drives the machine's item0..3_available inputs.
- Arbitrates the single coin hopper between change payout and cancel refund.

Parameters:
STOCK_W, 4, width of each per-slot stock counter (max stock 2^STOCK_W-1)
STOCK_INIT, 4, stock loaded into every slot at reset
MOTOR_TIMEOUT, 16, maximum motor-on cycles allowed while waiting for drop_sense
PULSE_HI, 2, coin_pulse high time in cycles
PULSE_LO, 2, coin_pulse low (gap) time in cycles

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-low
pdt  in  1  vend strobe from vending_machine
sel  in  2  slot index for the vend, sampled with the pdt rising edge
cng  in  3  change coin count, sampled with the pdt rising edge
rtn  in  3  refund coin count; nonzero means a cancel refund is requested
drop_sense  in  1  item-drop photo sensor
refill  in  1  refill strobe, one cycle
refill_sel  in  2  slot being refilled
refill_qty  in  STOCK_W  quantity added on refill
fault_clr  in  1  clears the sticky fault flag
motor  out  4  one-hot slot motor drive
coin_pulse  out  1  hopper eject pulse; one pulse is one coin
busy  out  1  high in every state except IDLE
fault  out  1  sticky fault flag
item_available  out  4  bit i = (stock[i] != 0), combinational from the stock registers
stock_level  out  STOCK_W  stock[refill_sel], combinational

Behaviour:
- Reset (rst low at a clk edge):
  - state = IDLE.
  - motor = 0, coin_pulse = 0, fault = 0.
  - Every stock[i] = STOCK_INIT.
  - Edge-detect registers = 0.
- Edge detection:
  - pdt_prev and rtn_nz_prev are registered every cycle.
  - A vend event is pdt & !pdt_prev.
  - A refund event is (rtn != 0) & !rtn_nz_prev.
  - A level held for several cycles is accepted exactly once.
- States: IDLE, MOTOR, PAY_HI, PAY_LO.
- IDLE:
  - Vend event with stock[sel] != 0: latch sel and pay_cnt = cng, decrement stock[sel], go to MOTOR.
  - Vend event with stock[sel] == 0: set fault, load pay_cnt = cng, go to PAY_HI (or stay in IDLE if cng == 0). Stock is unchanged.
  - Refund event (no vend event): pay_cnt = rtn, go to PAY_HI.
  - Vend and refund events in the same cycle: the vend wins and the refund is dropped.
- Events that arrive while busy are ignored; the edge registers still update.
- MOTOR:
  - motor = one-hot(latched sel) from the cycle after the vend event.
  - The timer counts cycles in MOTOR.
  - drop_sense high: next cycle motor = 0 and the state goes to PAY_HI (or to IDLE if pay_cnt == 0).
  - Timer reaches MOTOR_TIMEOUT without drop_sense: motor = 0, fault = 1, then payout proceeds as above. Stock is not restored.
- Payout:
  - PAY_HI: coin_pulse = 1 for PULSE_HI cycles.
  - PAY_LO: coin_pulse = 0 for PULSE_LO cycles, and pay_cnt decrements on PAY_LO entry.
  - At the end of PAY_LO: pay_cnt != 0 returns to PAY_HI; pay_cnt == 0 goes to IDLE.
  - Exactly pay_cnt pulses are produced; 0 to 7 coins are supported.
- Refill:
  - Accepted in any state.
  - stock[refill_sel] += refill_qty, saturating at 2^STOCK_W-1.
  - If the same slot is decremented in the same cycle: new value = sat(stock - 1 + qty).
- fault_clr clears fault. If a fault condition occurs in the same cycle, set wins.
- Reset asserted mid-operation aborts on that edge:
  - motor and coin_pulse drop to 0 immediately.
  - The pending payout is discarded.

Decomposition:
- Package vend_pkg holds:
  - NUM_ITEMS = 4 and the SLOT_W = 2 item-index typedef.
  - The coin-count typedef (3 bits).
  - The dispense state enum.
- One sub-module, vend_coin_pulser:
  - Interface: start, count, PULSE_HI/PULSE_LO parameters, coin_pulse, done.
  - Owns the PAY_HI/PAY_LO timing.
  - It is reused later for a second hopper.

Test Plan:
- Reset, then vend sel=2 cng=1 with drop_sense after 3 motor cycles:
  - motor=0100 for 3 cycles, then one 2-high/2-low coin_pulse.
  - stock[2]=3, busy low afterwards.
- rtn=3 held high for 5 cycles: exactly 3 coin_pulse pulses (12 cycles total), no motor activity.
- Vend with drop_sense never asserted: motor high for 16 cycles, then fault=1; cng pulses still paid; fault_clr clears it.
- Four vends on slot 0 with STOCK_INIT=4: item_available[0] falls after the 4th vend.
  - A 5th vend with cng=2 gives fault=1, no motor, 2 pulses.
- Refill slot 1 by 15 at stock 4: stock_level=15 (saturated). Refill in the same cycle as a slot-1 decrement: also 15.
- Reset asserted during PAY_HI:
  - coin_pulse=0 on the next edge.
  - No further pulses after rst releases.
  - All slots back to 4.
